lfsr_word_controller: RTL and testbench

- Sequences a 32-bit Fibonacci LFSR: accepts a seed over a handshake, runs a configurable warm-up, then serialises feedback bits into WORD_WIDTH-bit random words.
- Delivers words to one consumer over valid/ready.
- Sits between the seed source (software or config register) and downstream random-number consumers. It is the only agent that steps or loads the LFSR.

---
 rtl/lfsr_pkg.sv | 20 ++
 rtl/lfsr_word_controller_core.sv | 27 ++
 rtl/lfsr_word_controller.sv | 107 ++++++++++
 tb/tb_lfsr_word_controller.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR word controller: state encoding,
// feedback tap positions and register width.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    FILL   = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int LFSR_WIDTH = 32;
  localparam int TAP_A      = 31;
  localparam int TAP_B      = 6;
  localparam int TAP_C      = 5;
  localparam int TAP_D      = 1;

  localparam logic [LFSR_WIDTH-1:0] DEFAULT_SEED_C = 32'h0000_0001;

endpackage

// File: rtl/lfsr_word_controller_core.sv
// 32-bit Fibonacci LFSR register with a parallel load and a single-step enable;
// a load overrides a step in the same cycle.
module lfsr_core
  import lfsr_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic [LFSR_WIDTH-1:0] load_value,
  input  logic                  step_en,
  output logic [LFSR_WIDTH-1:0] q,
  output logic                  fb
);

  assign fb = q[TAP_A] ^ q[TAP_B] ^ q[TAP_C] ^ q[TAP_D];

  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else if (load_en) begin
      q <= load_value;
    end else if (step_en) begin
      q <= {q[LFSR_WIDTH-2:0], fb};
    end
  end

endmodule

// File: rtl/lfsr_word_controller.sv
// Seeds and sequences an LFSR: warm-up, then packs feedback bits MSB-first into
// words handed out over valid/ready. Define LFSR_CTRL_WORD_COUNT_EN to add word_count.
module lfsr_word_controller
  import lfsr_pkg::*;
#(
  parameter int                    WORD_WIDTH    = 8,
  parameter int                    WARMUP_CYCLES = 64,
  parameter logic [LFSR_WIDTH-1:0] DEFAULT_SEED  = DEFAULT_SEED_C
)
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  seed_valid,
  input  logic [LFSR_WIDTH-1:0] seed,
  output logic                  seed_ready,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic [WORD_WIDTH-1:0] word,
  output logic                  busy,
  output logic                  seeded
`ifdef LFSR_CTRL_WORD_COUNT_EN
  ,
  output logic [31:0]           word_count
`endif
);

  localparam logic [15:0] WARM_LAST = 16'((WARMUP_CYCLES == 0) ? 0 : WARMUP_CYCLES - 1);
  localparam logic [5:0]  BIT_LAST  = 6'(WORD_WIDTH - 1);

  state_t                  state;
  state_t                  state_next;
  logic [15:0]             warm_cnt;
  logic [5:0]              bit_cnt;
  logic                    accept;
  logic                    handshake;
  logic                    fb;
  logic [LFSR_WIDTH-1:0]   q;
  logic [LFSR_WIDTH-1:0]   load_value;

  assign seed_ready = (state == IDLE) || (state == HOLD);
  assign word_valid = (state == HOLD);
  assign busy       = (state == WARMUP) || (state == FILL);
  assign accept     = seed_valid && seed_ready;
  assign handshake  = word_valid && word_ready;
  // An all-zero seed would lock the LFSR, so it is replaced.
  assign load_value = (seed == '0) ? DEFAULT_SEED : seed;

  lfsr_core u_core (
    .clock      (clock),
    .reset      (reset),
    .load_en    (accept),
    .load_value (load_value),
    .step_en    (busy),
    .q          (q),
    .fb         (fb)
  );

  always_comb begin
    state_next = state;
    if (accept) begin
      if (WARMUP_CYCLES == 0) state_next = FILL;
      else                    state_next = WARMUP;
    end else begin
      case (state)
        WARMUP:  if (warm_cnt == WARM_LAST) state_next = FILL;
        FILL:    if (bit_cnt == BIT_LAST)   state_next = HOLD;
        HOLD:    if (handshake)             state_next = FILL;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      warm_cnt <= '0;
      bit_cnt  <= '0;
      word     <= '0;
      seeded   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        seeded   <= 1'b1;
        warm_cnt <= '0;
        bit_cnt  <= '0;
      end else begin
        if (state == WARMUP) warm_cnt <= warm_cnt + 16'd1;
        if (state == FILL) begin
          // Truncating {word, fb} keeps the low bits, which also covers a 1-bit word.
          word    <= WORD_WIDTH'({word, fb});
          bit_cnt <= (bit_cnt == BIT_LAST) ? 6'd0 : bit_cnt + 6'd1;
        end
      end
    end
  end

`ifdef LFSR_CTRL_WORD_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset || accept) begin
      word_count <= '0;
    end else if (handshake) begin
      word_count <= word_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_word_controller.sv
// Directed and randomized checks of lfsr_word_controller against a bit-serial
// reference model; two instances cover zero and 64-cycle warm-up.
module tb_lfsr_word_controller;
  import lfsr_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        sv0, sv1, wr0, wr1;
  logic [31:0] s0, s1;
  logic        sr0, sr1, wv0, wv1, b0, b1, sd0, sd1;
  logic [7:0]  w0, w1;
`ifdef LFSR_CTRL_WORD_COUNT_EN
  logic [31:0] wc0, wc1;
`endif

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] mq;
  logic [31:0] seedv;
  logic [7:0]  ew;
  int          n, nw, d;
  int          mcount;

  lfsr_word_controller #(.WORD_WIDTH(8), .WARMUP_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset), .seed_valid(sv0), .seed(s0), .seed_ready(sr0),
    .word_valid(wv0), .word_ready(wr0), .word(w0), .busy(b0), .seeded(sd0)
`ifdef LFSR_CTRL_WORD_COUNT_EN
    , .word_count(wc0)
`endif
  );

  lfsr_word_controller #(.WORD_WIDTH(8), .WARMUP_CYCLES(64)) dut64 (
    .clock(clock), .reset(reset), .seed_valid(sv1), .seed(s1), .seed_ready(sr1),
    .word_valid(wv1), .word_ready(wr1), .word(w1), .busy(b1), .seeded(sd1)
`ifdef LFSR_CTRL_WORD_COUNT_EN
    , .word_count(wc1)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: one feedback bit per step from the tap polynomial, shifted into q.
  function automatic logic model_bit(input logic [31:0] v);
    return v[31] ^ v[6] ^ v[5] ^ v[1];
  endfunction

  task automatic model_steps(input int count);
    for (int i = 0; i < count; i++) mq = (mq << 1) | 32'(model_bit(mq));
  endtask

  task automatic gen_word(output logic [7:0] w);
    int acc;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      acc = acc * 2 + int'(model_bit(mq));
      mq  = (mq << 1) | 32'(model_bit(mq));
    end
    w = acc[7:0];
  endtask

  task automatic chk_reset_values();
    chk("rst_state0", dut0.state, IDLE);
    chk("rst_ready0", sr0, 1'b1);
    chk("rst_valid0", wv0, 1'b0);
    chk("rst_busy0", b0, 1'b0);
    chk("rst_seeded0", sd0, 1'b0);
    chk("rst_word0", w0, 8'h00);
    chk("rst_q0", dut0.u_core.q, 32'h0);
    chk("rst_state64", dut64.state, IDLE);
    chk("rst_ready64", sr1, 1'b1);
    chk("rst_valid64", wv1, 1'b0);
    chk("rst_busy64", b1, 1'b0);
    chk("rst_seeded64", sd1, 1'b0);
    chk("rst_word64", w1, 8'h00);
`ifdef LFSR_CTRL_WORD_COUNT_EN
    chk("rst_count0", wc0, 32'h0);
    chk("rst_count64", wc1, 32'h0);
`endif
  endtask

  initial begin
    // Reset with seeds offered: nothing may be accepted.
    reset = 1'b1; sv0 = 1'b1; s0 = 32'h5; sv1 = 1'b1; s1 = 32'h7; wr0 = 1'b0; wr1 = 1'b0;
    tick(); tick();
    reset = 1'b0; sv0 = 1'b0; sv1 = 1'b0;
    tick();
    chk_reset_values();

    // Known sequence: seed 1, no warm-up.
    s0 = 32'h1; sv0 = 1'b1;
    tick();
    sv0 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk("known_busy", b0, 1'b1);
      chk("known_nvalid", wv0, 1'b0);
      chk("known_nready", sr0, 1'b0);
      tick();
    end
    mq = 32'h1;
    gen_word(ew);
    chk("known_valid", wv0, 1'b1);
    chk("known_word_const", w0, 8'h53);
    chk("known_word_model", w0, ew);
    chk("known_q", dut0.u_core.q, 32'h153);
    chk("known_busy_low", b0, 1'b0);
    chk("known_seeded", sd0, 1'b1);

    // Back-pressure: word and q hold while word_ready is low.
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_valid", wv0, 1'b1);
      chk("bp_word", w0, 8'h53);
      chk("bp_q", dut0.u_core.q, 32'h153);
    end
    wr0 = 1'b1;
    tick();
    wr0 = 1'b0;
    gen_word(ew);
    for (int k = 1; k <= 9; k++) begin
      chk("bp_next_valid", wv0, (k == 9));
      if (k < 9) tick();
    end
    chk("bp_next_word", w0, ew);
    chk("bp_next_q", dut0.u_core.q, mq);
`ifdef LFSR_CTRL_WORD_COUNT_EN
    chk("bp_count", wc0, 32'd1);
`endif

    // Zero reseed together with a handshake in HOLD.
    s0 = 32'h0; sv0 = 1'b1; wr0 = 1'b1;
    tick();
    sv0 = 1'b0; wr0 = 1'b0;
    chk("reseed_valid_drop", wv0, 1'b0);
    chk("reseed_busy", b0, 1'b1);
`ifdef LFSR_CTRL_WORD_COUNT_EN
    chk("reseed_count_clear", wc0, 32'd0);
`endif
    repeat (8) tick();
    chk("zero_seed_valid", wv0, 1'b1);
    chk("zero_seed_word", w0, 8'h53);
    chk("zero_seed_q", dut0.u_core.q, 32'h153);
    chk("zero_seed_seeded", sd0, 1'b1);

    // 64-cycle warm-up with a seed held high throughout the busy phase.
    seedv = $urandom;
    s1 = seedv; sv1 = 1'b1;
    tick();
    s1 = seedv ^ 32'hA5A5_0F0F;
    for (int c = 1; c <= 72; c++) begin
      chk("warm_nready", sr1, 1'b0);
      chk("warm_nvalid", wv1, 1'b0);
      chk("warm_busy", b1, 1'b1);
      tick();
    end
    sv1 = 1'b0;
    mq = (seedv == 0) ? 32'h1 : seedv;
    model_steps(64);
    gen_word(ew);
    chk("warm_valid73", wv1, 1'b1);
    chk("warm_word", w1, ew);
    chk("warm_q", dut64.u_core.q, mq);

    // Reseed, then reset at cycle 30 of warm-up.
    s1 = 32'h1234_5678; sv1 = 1'b1;
    tick();
    sv1 = 1'b0;
    repeat (29) tick();
    chk("midrun_busy", b1, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_values();

    // Randomized seeds, word counts and stalls against the model.
    for (int it = 0; it < 6; it++) begin
      seedv = $urandom;
      if ($urandom_range(0, 3) == 0) seedv = 32'h0;
      s0 = seedv; sv0 = 1'b1;
      tick();
      sv0 = 1'b0;
      mq = (seedv == 0) ? 32'h1 : seedv;
      mcount = 0;
      nw = $urandom_range(1, 3);
      for (int k = 0; k < nw; k++) begin
        n = 1;
        while (wv0 !== 1'b1 && n < 20) begin
          tick();
          n++;
        end
        chk("rnd_latency", n, 9);
        gen_word(ew);
        chk("rnd_word", w0, ew);
`ifdef LFSR_CTRL_WORD_COUNT_EN
        chk("rnd_count", wc0, mcount);
`endif
        d = $urandom_range(0, 3);
        repeat (d) begin
          tick();
          chk("rnd_stall_word", w0, ew);
          chk("rnd_stall_valid", wv0, 1'b1);
        end
        if (k != nw - 1) begin
          wr0 = 1'b1;
          tick();
          wr0 = 1'b0;
          mcount++;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
